// File: rtl/spi_load_slave.sv
// SPI/QSPI slave for the file-load protocol: register write/read frames and
// memory-write frames, turned into 32-bit write requests through a small FIFO.
module spi_load_slave #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sck,
    input  logic        spi_csn,
    input  logic        spi_sdi0,
    input  logic        spi_sdi1,
    input  logic        spi_sdi2,
    input  logic        spi_sdi3,
    output logic        spi_sdo0,
    output logic        spi_sdo0_oe,
    output logic        qpi_mode,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic        overflow,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        REG_WR,
        REG_RD,
        IGNORE
    } state_e;

    localparam logic [7:0] CMD_REG_WR = 8'h01;
    localparam logic [7:0] CMD_MEM_WR = 8'h02;
    localparam logic [7:0] CMD_REG_RD = 8'h05;

    // Synchronizer lanes packed as {csn, sck, sdi3..sdi0}; csn idles high.
    localparam logic [5:0] SYNC_RST = 6'b10_0000;

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_FILL = (PTR_W + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input synchronization and edge detection
    // ------------------------------------------------------------------
    logic [5:0] sync_q [SYNC_STAGES];
    logic       sck_prev_q;
    logic       csn_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
            sck_prev_q <= 1'b0;
            csn_prev_q <= 1'b1;
        end else begin
            sync_q[0] <= {spi_csn, spi_sck, spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sck_prev_q <= sync_q[SYNC_STAGES-1][4];
            csn_prev_q <= sync_q[SYNC_STAGES-1][5];
        end
    end

    logic       csn_s;
    logic       sck_s;
    logic [3:0] sdi_s;
    logic       sck_rise;
    logic       sck_fall;
    logic       csn_fall;
    logic       csn_rise;

    assign csn_s    = sync_q[SYNC_STAGES-1][5];
    assign sck_s    = sync_q[SYNC_STAGES-1][4];
    assign sdi_s    = sync_q[SYNC_STAGES-1][3:0];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign csn_fall = ~csn_s & csn_prev_q;
    assign csn_rise = csn_s & ~csn_prev_q;

    // ------------------------------------------------------------------
    // Frame decoder
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  reg0_q, reg0_d;
    logic [7:0]  rd_shift_q, rd_shift_d;
    logic        rd_oe_q, rd_oe_d;
    logic        quad_q, quad_d;
    logic        frame_err_q, frame_err_d;

    logic [31:0] shift_in;
    logic [5:0]  cnt_inc;
    logic [5:0]  field_len;
    logic        field_done;
    logic        push;
    logic [63:0] push_data;

    assign shift_in   = quad_q ? {shift_q[27:0], sdi_s} : {shift_q[30:0], sdi_s[0]};
    assign cnt_inc    = cnt_q + 6'd1;
    assign field_done = sck_rise && (cnt_inc == field_len);
    assign push_data  = {addr_q, shift_in};

    always_comb begin
        case (state_q)
            CMD, REG_WR: field_len = quad_q ? 6'd2 : 6'd8;
            default:     field_len = quad_q ? 6'd8 : 6'd32;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        reg0_d      = reg0_q;
        rd_shift_d  = rd_shift_q;
        rd_oe_d     = rd_oe_q;
        quad_d      = quad_q;
        frame_err_d = 1'b0;
        push        = 1'b0;

        if (csn_s) begin
            state_d    = IDLE;
            cnt_d      = '0;
            rd_oe_d    = 1'b0;
            rd_shift_d = '0;
            if (csn_rise) begin
                case (state_q)
                    CMD, ADDR, DATA: frame_err_d = (cnt_q != '0);
                    REG_WR:          frame_err_d = 1'b1;
                    default:         frame_err_d = 1'b0;
                endcase
            end
        end else begin
            if (sck_rise && (state_q inside {CMD, ADDR, DATA, REG_WR})) begin
                shift_d = shift_in;
                cnt_d   = field_done ? '0 : cnt_inc;
            end
            if (sck_fall && rd_oe_q) rd_shift_d = {rd_shift_q[6:0], 1'b0};

            case (state_q)
                IDLE: begin
                    if (csn_fall) begin
                        state_d = CMD;
                        cnt_d   = '0;
                        quad_d  = reg0_q[0];
                    end
                end
                CMD: begin
                    if (field_done) begin
                        case (shift_in[7:0])
                            CMD_REG_WR: state_d = REG_WR;
                            CMD_MEM_WR: state_d = ADDR;
                            CMD_REG_RD: begin
                                state_d    = REG_RD;
                                rd_oe_d    = 1'b1;
                                rd_shift_d = reg0_q;
                            end
                            default:    state_d = IGNORE;
                        endcase
                    end
                end
                REG_WR: begin
                    // Only one byte per frame is taken; the rest is dropped.
                    if (field_done) begin
                        reg0_d  = shift_in[7:0];
                        state_d = IGNORE;
                    end
                end
                ADDR: begin
                    if (field_done) begin
                        addr_d  = {shift_in[31:2], 2'b00};
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (field_done) begin
                        push   = 1'b1;
                        addr_d = addr_q + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            reg0_q      <= '0;
            rd_shift_q  <= '0;
            rd_oe_q     <= 1'b0;
            quad_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            reg0_q      <= reg0_d;
            rd_shift_q  <= rd_shift_d;
            rd_oe_q     <= rd_oe_d;
            quad_q      <= quad_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Write-request FIFO
    // ------------------------------------------------------------------
    logic [63:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0] fill;
    logic           fifo_empty;
    logic           fifo_full;
    logic           pop;
    logic           push_ok;
    logic           overflow_q;
    logic [63:0]    head;

    assign fill       = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == FULL_FILL);
    assign pop        = !fifo_empty && mem_req_ready;
    // A same-cycle pop frees the slot the push needs.
    assign push_ok    = push && (!fifo_full || pop);

    // NOTE: the storage array has no reset; only the pointers define which
    // entries are valid, and the outputs are gated while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !push_ok) overflow_q <= 1'b1;
        end
    end

    assign head = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req_valid = !fifo_empty;
    assign mem_req_addr  = fifo_empty ? 32'd0 : head[63:32];
    assign mem_req_wdata = fifo_empty ? 32'd0 : head[31:0];
    assign overflow      = overflow_q;
    assign frame_err     = frame_err_q;
    assign qpi_mode      = reg0_q[0];
    assign spi_sdo0      = rd_shift_q[7];
    assign spi_sdo0_oe   = rd_oe_q;

endmodule

// File: tb/tb_spi_load_slave.sv
// Self-checking bench for spi_load_slave: an SPI master model drives frames and
// a transaction-level model predicts register state and memory write requests.
module tb_spi_load_slave;

    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_sck;
    logic        spi_csn;
    logic        spi_sdi0, spi_sdi1, spi_sdi2, spi_sdi3;
    logic        spi_sdo0;
    logic        spi_sdo0_oe;
    logic        qpi_mode;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        overflow;
    logic        frame_err;

    spi_load_slave #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_sck      (spi_sck),
        .spi_csn      (spi_csn),
        .spi_sdi0     (spi_sdi0),
        .spi_sdi1     (spi_sdi1),
        .spi_sdi2     (spi_sdi2),
        .spi_sdi3     (spi_sdi3),
        .spi_sdo0     (spi_sdo0),
        .spi_sdo0_oe  (spi_sdo0_oe),
        .qpi_mode     (qpi_mode),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .overflow     (overflow),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  m_reg0;
    logic        m_overflow;
    logic        tb_quad;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          fe_pulses = 0;

    // Observe accepted requests and frame_err pulses mid-cycle.
    always @(negedge clk) begin
        #1;
        if (mem_req_valid && mem_req_ready) got_q.push_back({mem_req_addr, mem_req_wdata});
        if (frame_err) fe_pulses++;
    end

    // ---------------- SPI master and reference model ----------------
    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_begin();
        tb_quad = m_reg0[0];
        spi_csn = 1'b0;
        half();
    endtask

    task automatic frame_end();
        half();
        spi_csn = 1'b1;
        half();
        half();
    endtask

    // Send the first nsend bits (MSB first) of a width-bit field.
    task automatic send_bits(input logic [31:0] v, input int width, input int nsend);
        int pos = width;
        while (pos > width - nsend) begin
            if (tb_quad) begin
                {spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0} = v[pos-1 -: 4];
                pos -= 4;
            end else begin
                spi_sdi0 = v[pos-1];
                pos -= 1;
            end
            half();
            spi_sck = 1'b1;
            half();
            spi_sck = 1'b0;
        end
    endtask

    task automatic reg_write(input logic [7:0] b);
        frame_begin();
        send_bits(32'h01, 8, 8);
        send_bits({24'h0, b}, 8, 8);
        frame_end();
        m_reg0 = b;
    endtask

    task automatic mem_write(input logic [31:0] addr, input logic [31:0] words[$]);
        frame_begin();
        send_bits(32'h02, 8, 8);
        send_bits(addr, 32, 32);
        foreach (words[i]) send_bits(words[i], 32, 32);
        frame_end();
    endtask

    // Expected requests: word i lands at the word-aligned base plus 4*i (mod 2^32);
    // only the first accept_max words fit, the rest set overflow.
    task automatic model_write(input logic [31:0] addr, input logic [31:0] words[$],
                               input int accept_max);
        logic [31:0] a;
        a = addr - (addr % 4);
        foreach (words[i]) begin
            if (i < accept_max) exp_q.push_back({a, words[i]});
            else m_overflow = 1'b1;
            a = a + 32'd4;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (mem_req_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s drain timeout: valid=%b required 0", name, mem_req_valid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; spi_csn = 1'b1; spi_sck = 1'b0; mem_req_ready = 1'b0;
        {spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0} = 4'h0;
        m_reg0 = 8'h00; m_overflow = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req_valid, spi_sdo0, spi_sdo0_oe, qpi_mode, overflow, frame_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset flags: got %b required 000000",
                     {mem_req_valid, spi_sdo0, spi_sdo0_oe, qpi_mode, overflow, frame_err});
        end
        checks++;
        if ({mem_req_addr, mem_req_wdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset mem bus: got %h required 0", {mem_req_addr, mem_req_wdata});
        end
    endtask

    task automatic test_reg_write();
        int fe0 = fe_pulses;
        got_q.delete();
        reg_write(8'h01);
        checks++;
        if (qpi_mode !== m_reg0[0]) begin
            errors++; $display("FAIL reg_write qpi_mode: got %b required %b", qpi_mode, m_reg0[0]);
        end
        checks++;
        if (fe_pulses != fe0) begin
            errors++; $display("FAIL reg_write frame_err: got %0d pulses required 0", fe_pulses - fe0);
        end
        checks++;
        if (got_q.size() != 0 || mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL reg_write mem: got %0d requests required 0", got_q.size());
        end
    endtask

    task automatic test_quad_write();
        logic [31:0] w[$];
        logic [31:0] a;
        got_q.delete(); exp_q.delete();
        mem_req_ready = 1'b1;
        w.push_back(32'hDEADBEEF); w.push_back(32'h12345678);
        mem_write(32'h0010_0000, w);
        model_write(32'h0010_0000, w, 99);
        w.delete();
        a = $urandom;
        repeat ($urandom_range(1, 3)) w.push_back($urandom);
        mem_write(a, w);
        model_write(a, w, 99);
        wait_drain("quad_write");
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL quad_write count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL quad_write req%0d: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 64'hx, exp_q[i]);
            end
        end
        reg_write(8'h00);
        checks++;
        if (qpi_mode !== 1'b0) begin
            errors++; $display("FAIL quad_exit qpi_mode: got %b required 0", qpi_mode);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] w[$];
        got_q.delete(); exp_q.delete();
        mem_req_ready = 1'b0;
        repeat (6) w.push_back($urandom);
        mem_write(32'h0, w);
        model_write(32'h0, w, FIFO_DEPTH);
        repeat (5) @(negedge clk);
        checks++;
        if ({mem_req_valid, overflow} !== {1'b1, m_overflow}) begin
            errors++; $display("FAIL overflow flags: got valid=%b ovf=%b required 1 %b",
                               mem_req_valid, overflow, m_overflow);
        end
        checks++;
        if ({mem_req_addr, mem_req_wdata} !== exp_q[0]) begin
            errors++; $display("FAIL overflow stalled head: got %h required %h",
                               {mem_req_addr, mem_req_wdata}, exp_q[0]);
        end
        mem_req_ready = 1'b1;
        wait_drain("overflow");
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL overflow count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL overflow req%0d: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 64'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic [31:0] w[$];
        logic [31:0] a;
        int cyc = 0;
        got_q.delete(); exp_q.delete();
        mem_req_ready = 1'b0;
        a = $urandom;
        w.push_back($urandom);
        model_write(a, w, 99);
        frame_begin();
        send_bits(32'h02, 8, 8);
        send_bits(a, 32, 32);
        send_bits(w[0], 32, 31);
        spi_sdi0 = w[0][0];
        half();
        spi_sck = 1'b1;
        while (!mem_req_valid && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!mem_req_valid || cyc > SYNC_STAGES + 2) begin
            errors++; $display("FAIL latency: got %0d cycles required <= %0d", cyc, SYNC_STAGES + 2);
        end
        half();
        spi_sck = 1'b0;
        frame_end();
        mem_req_ready = 1'b1;
        wait_drain("latency");
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL latency req: got %0d reqs, first %h required %h",
                               got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'hx, exp_q[0]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] w[$];
        got_q.delete(); exp_q.delete();
        mem_req_ready = 1'b1;
        w.push_back($urandom); w.push_back($urandom);
        mem_write(32'hFFFF_FFFC, w);
        model_write(32'hFFFF_FFFC, w, 99);
        w.delete();
        w.push_back($urandom);
        mem_write(32'h0000_0013, w);
        model_write(32'h0000_0013, w, 99);
        wait_drain("wrap");
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL wrap count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap req%0d: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 64'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_frame_err();
        logic [31:0] w[$];
        logic [31:0] a, w2;
        int fe0 = fe_pulses;
        got_q.delete(); exp_q.delete();
        mem_req_ready = 1'b1;
        a = $urandom;
        w.push_back($urandom);
        w2 = $urandom;
        model_write(a, w, 99);
        frame_begin();
        send_bits(32'h02, 8, 8);
        send_bits(a, 32, 32);
        send_bits(w[0], 32, 32);
        send_bits(w2, 32, 20);
        frame_end();
        checks++;
        if (fe_pulses - fe0 != 1) begin
            errors++; $display("FAIL frame_err data pulses: got %0d required 1", fe_pulses - fe0);
        end
        w.delete();
        a = $urandom;
        w.push_back($urandom);
        mem_write(a, w);
        model_write(a, w, 99);
        wait_drain("frame_err");
        checks++;
        if (fe_pulses - fe0 != 1) begin
            errors++; $display("FAIL frame_err clean frame: got %0d pulses required 1", fe_pulses - fe0);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL frame_err count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL frame_err req%0d: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 64'hx, exp_q[i]);
            end
        end
        frame_begin();
        send_bits(32'h02, 8, 4);
        frame_end();
        checks++;
        if (fe_pulses - fe0 != 2) begin
            errors++; $display("FAIL frame_err cmd partial: got %0d pulses required 2", fe_pulses - fe0);
        end
        frame_begin();
        send_bits(32'h01, 8, 8);
        send_bits(32'hFF, 8, 4);
        frame_end();
        checks++;
        if (fe_pulses - fe0 != 3 || qpi_mode !== m_reg0[0]) begin
            errors++; $display("FAIL frame_err reg partial: got %0d pulses qpi=%b required 3 qpi=%b",
                               fe_pulses - fe0, qpi_mode, m_reg0[0]);
        end
    endtask

    task automatic test_reg_read();
        logic [7:0] vals[2];
        vals[0] = 8'hA5;
        vals[1] = 8'($urandom);
        foreach (vals[k]) begin
            reg_write(vals[k]);
            frame_begin();
            send_bits(32'h05, 8, tb_quad ? 4 : 7);
            if (tb_quad) {spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0} = 4'h5;
            else spi_sdi0 = 1'b1;
            for (int i = 7; i >= -1; i--) begin
                half();
                spi_sck = 1'b1;
                half();
                checks++;
                if (spi_sdo0_oe !== 1'b1 || spi_sdo0 !== ((i >= 0) ? m_reg0[i & 7] : 1'b0)) begin
                    errors++;
                    $display("FAIL reg_read %h bit%0d: got sdo=%b oe=%b required sdo=%b oe=1", m_reg0, i,
                             spi_sdo0, spi_sdo0_oe, (i >= 0) ? m_reg0[i & 7] : 1'b0);
                end
                if (i < 7) spi_sck = 1'b0;
                else begin
                    spi_sck = 1'b0;
                end
            end
            frame_end();
            checks++;
            if (spi_sdo0_oe !== 1'b0) begin
                errors++; $display("FAIL reg_read oe after csn: got %b required 0", spi_sdo0_oe);
            end
        end
        reg_write(8'h00);
    endtask

    task automatic test_reset_mid();
        logic [31:0] w[$];
        logic [31:0] a;
        reg_write(8'h01);
        frame_begin();
        send_bits(32'h02, 8, 8);
        send_bits($urandom, 32, 16);
        rst_n = 1'b0;
        @(negedge clk);
        m_reg0 = 8'h00; m_overflow = 1'b0;
        checks++;
        if ({mem_req_valid, spi_sdo0, spi_sdo0_oe, qpi_mode, overflow, frame_err,
             mem_req_addr, mem_req_wdata} !== 70'h0) begin
            errors++; $display("FAIL reset_mid outputs: valid=%b qpi=%b ovf=%b addr=%h required all 0",
                               mem_req_valid, qpi_mode, overflow, mem_req_addr);
        end
        spi_csn = 1'b1;
        spi_sck = 1'b0;
        half();
        rst_n = 1'b1;
        half();
        got_q.delete(); exp_q.delete();
        mem_req_ready = 1'b1;
        a = $urandom;
        w.push_back($urandom);
        mem_write(a, w);
        model_write(a, w, 99);
        wait_drain("reset_mid");
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0] || overflow !== m_overflow) begin
            errors++; $display("FAIL reset_mid next frame: got %0d reqs first %h ovf=%b required 1 %h ovf=%b",
                               got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'hx, overflow,
                               exp_q[0], m_overflow);
        end
    endtask

    task automatic test_random();
        logic [31:0] w[$];
        logic [31:0] a;
        got_q.delete(); exp_q.delete();
        mem_req_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                reg_write(8'($urandom));
                checks++;
                if (qpi_mode !== m_reg0[0]) begin
                    errors++; $display("FAIL random%0d qpi_mode: got %b required %b", f, qpi_mode, m_reg0[0]);
                end
            end
            w.delete();
            a = $urandom;
            repeat ($urandom_range(1, 3)) w.push_back($urandom);
            mem_write(a, w);
            model_write(a, w, 99);
        end
        wait_drain("random");
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random req%0d: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 64'hx, exp_q[i]);
            end
        end
        checks++;
        if (overflow !== m_overflow) begin
            errors++; $display("FAIL random overflow: got %b required %b", overflow, m_overflow);
        end
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_quad_write();
        test_overflow();
        test_latency();
        test_wrap();
        test_frame_err();
        test_reg_read();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
